// File: rtl/forward_ctrl_if.sv
// Decode/forwarding bus between the pipeline decode stage and forward_ctrl.
// master drives decode fields; slave (forward_ctrl) returns mux selects and stall.
interface forward_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic              advance;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              load_stall;

    modport master (
        output advance, ex_valid, ex_rd, ex_regwrite, ex_memread, id_rn, id_rm,
        input  sel_a, sel_b, load_stall
    );

    modport slave (
        input  advance, ex_valid, ex_rd, ex_regwrite, ex_memread, id_rn, id_rm,
        output sel_a, sel_b, load_stall
    );
endinterface

// File: rtl/forward_ctrl.sv
// Operand-forwarding control: tracks the last three producers (EX/MEM/WB) and
// registers 4:1 operand mux selects. Optional load-use stall via FWD_LOAD_STALL_EN.
module forward_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic            clk,
    input  logic            reset_n,
    forward_ctrl_if.slave   bus
);
    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } trk_t;

    trk_t       s1, s2, s3;
    trk_t       s1_next;
    logic [1:0] sel_a_q, sel_b_q;
    logic       stall_c;
    logic       unused_s3_memread;

    // Entry produces a value the consumer needs; the zero register never forwards.
    function automatic logic hit(input trk_t e, input logic [REG_AW-1:0] r);
        return e.valid && e.regwrite && (e.rd == r) && (r != ZR);
    endfunction

    // Youngest producer wins.
    function automatic logic [1:0] fwd_sel(input trk_t e1, input trk_t e2, input trk_t e3,
                                           input logic [REG_AW-1:0] r);
        if (hit(e1, r))      return 2'b01;
        else if (hit(e2, r)) return 2'b10;
        else if (hit(e3, r)) return 2'b11;
        else                 return 2'b00;
    endfunction

`ifdef FWD_LOAD_STALL_EN
    // A load still in EX cannot forward to the instruction right behind it.
    assign stall_c = reset_n && s1.memread &&
                     (hit(s1, bus.id_rn) || hit(s1, bus.id_rm));
`else
    assign stall_c = 1'b0;
`endif

    always_comb begin
        s1_next = '0;
        if (bus.ex_valid && !stall_c) begin
            s1_next.valid    = 1'b1;
            s1_next.rd       = bus.ex_rd;
            s1_next.regwrite = bus.ex_regwrite;
            s1_next.memread  = bus.ex_memread;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            sel_a_q <= 2'b00;
            sel_b_q <= 2'b00;
        end else if (bus.advance) begin
            s3      <= s2;
            s2      <= s1;
            s1      <= s1_next;
            sel_a_q <= stall_c ? 2'b00 : fwd_sel(s1, s2, s3, bus.id_rn);
            sel_b_q <= stall_c ? 2'b00 : fwd_sel(s1, s2, s3, bus.id_rm);
        end
    end

    assign bus.sel_a      = sel_a_q;
    assign bus.sel_b      = sel_b_q;
    assign bus.load_stall = stall_c;

    // The WB entry's load flag has no consumer once it retires.
    assign unused_s3_memread = s3.memread;
endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: the driver pushes hand-computed expectations,
// a monitor pops one per cycle and checks load_stall (pre-edge) and sel_a/sel_b (post-edge).
module tb_forward_ctrl;
    localparam int unsigned REG_AW = 5;

    typedef struct {
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        string      name;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n;
    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    logic   busy = 1'b0;

    forward_ctrl_if #(.REG_AW(REG_AW)) bus ();

    forward_ctrl #(.REG_AW(REG_AW), .ZERO_REG(31)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp_v);
        end
    endtask

    // Monitor: stall sampled at negedge with the cycle's inputs, selects after the edge.
    initial begin
        exp_t e;
        logic st;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                busy = 1'b1;
                e = q.pop_front();
                st = bus.load_stall;
                @(posedge clk);
                #1;
                chk({e.name, " stall"}, {1'b0, st}, {1'b0, e.es});
                chk({e.name, " sel_a"}, bus.sel_a, e.ea);
                chk({e.name, " sel_b"}, bus.sel_b, e.eb);
                busy = 1'b0;
            end
        end
    end

    task automatic cyc(input logic rstn, input logic adv, input logic ev,
                       input int rd, input logic rw, input logic mr,
                       input int rn, input int rm,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es,
                       input string name);
        exp_t e;
        reset_n         = rstn;
        bus.advance     = adv;
        bus.ex_valid    = ev;
        bus.ex_rd       = REG_AW'(rd);
        bus.ex_regwrite = rw;
        bus.ex_memread  = mr;
        bus.id_rn       = REG_AW'(rn);
        bus.id_rm       = REG_AW'(rm);
        e.ea = ea; e.eb = eb; e.es = es; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.advance = 1'b1; bus.ex_valid = 1'b0; bus.ex_rd = '0;
        bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
        bus.id_rn = '0; bus.id_rm = '0;
        @(posedge clk);
        #2;

        //  rstn adv ev rd rw mr rn rm  sel_a  sel_b  stall
        cyc(0, 1, 1, 3, 1, 0, 3, 3,  2'b00, 2'b00, 0, "reset");
        cyc(1, 1, 1, 3, 1, 0, 0, 1,  2'b00, 2'b00, 0, "add_rd3");
        cyc(1, 1, 1, 5, 1, 0, 3, 4,  2'b01, 2'b00, 0, "b2b_ex");
        cyc(1, 1, 1, 5, 1, 0, 3, 5,  2'b10, 2'b01, 0, "s2_fwd");
        cyc(1, 1, 1, 7, 0, 0, 3, 5,  2'b11, 2'b01, 0, "prio_s1");
        cyc(1, 1, 0, 5, 1, 0, 5, 7,  2'b10, 2'b00, 0, "nowrite");
        cyc(1, 1, 0, 0, 0, 0, 2, 5,  2'b00, 2'b11, 0, "s3_only");
        cyc(1, 1, 1, 31, 1, 0, 0, 0, 2'b00, 2'b00, 0, "w_r31");
        cyc(1, 1, 1, 9, 1, 0, 31, 31, 2'b00, 2'b00, 0, "zero_reg");
        cyc(1, 1, 0, 0, 0, 0, 9, 31, 2'b01, 2'b00, 0, "pre_hold");
        cyc(1, 0, 1, 1, 1, 0, 9, 9,  2'b01, 2'b00, 0, "hold1");
        cyc(1, 0, 1, 2, 1, 1, 1, 2,  2'b01, 2'b00, 0, "hold2");
        cyc(1, 0, 1, 9, 1, 0, 31, 9, 2'b01, 2'b00, 0, "hold3");
        cyc(1, 1, 0, 0, 0, 0, 9, 31, 2'b10, 2'b00, 0, "post_hold");
        cyc(1, 1, 1, 2, 1, 1, 0, 1,  2'b00, 2'b00, 0, "load_rd2");
`ifdef FWD_LOAD_STALL_EN
        cyc(1, 1, 1, 6, 1, 0, 2, 6,  2'b00, 2'b00, 1, "load_use");
        cyc(1, 1, 1, 6, 1, 0, 2, 6,  2'b10, 2'b00, 0, "after_bub");
`else
        cyc(1, 1, 1, 6, 1, 0, 2, 6,  2'b01, 2'b00, 0, "load_use");
        cyc(1, 1, 1, 6, 1, 0, 2, 6,  2'b10, 2'b01, 0, "after_bub");
`endif
        cyc(1, 1, 1, 4, 1, 1, 0, 0,  2'b00, 2'b00, 0, "load_rd4");
        cyc(0, 0, 1, 4, 1, 1, 4, 4,  2'b00, 2'b00, 0, "rst_stall");
        cyc(1, 1, 0, 0, 0, 0, 4, 4,  2'b00, 2'b00, 0, "post_rst");
        cyc(1, 1, 1, 19, 1, 0, 0, 0, 2'b00, 2'b00, 0, "w_r19");
        cyc(1, 1, 0, 0, 0, 0, 3, 19, 2'b00, 2'b01, 0, "full_width");

        for (int i = 0; i < 10 && (q.size() != 0 || busy); i++) @(posedge clk);
        #3;
        if (q.size() != 0 || busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
